frame_buffer_reader: RTL and testbench
======================================

# frame_buffer_reader

Consumer side of the game-to-display frame interface. The game engine writes a packed 1344-bit cell bitmap (`frame_in`). At each vertical-sync boundary this block requests a stable frame and snapshots it into a shadow register. It then answers per-pixel lookups from the VGA timing path with a fixed 2-cycle pipeline, so a frame never tears mid-scan.

## Interface
- `COLS`, 48, grid columns
- `ROWS`, 28, grid rows; COLS*ROWS = 1344 (width of `frame_in`)
- `CELL_SHIFT`, 3, log2 of cell edge in pixels (8x8 cells)
- `X0`, 128, left pixel edge of grid window
- `Y0`, 128, top pixel edge of grid window
- `TIMEOUT`, 1024, max cycles to wait for `frame_ready`

- `clk` in 1: system clock (CLOCK_50); single clock domain
- `rst` in 1: synchronous, active-low reset
- `frame_in` in 1344: packed bitmap from game; bit index = row*COLS+col, bit 0 = top-left cell
- `frame_ready` in 1: game asserts while `frame_in` is stable and may be sampled
- `frame_req` out 1: high while the block is waiting to snapshot a frame
- `vsync_start` in 1: one-cycle pulse at start of vertical blanking
- `pix_x` in 10: current pixel column
- `pix_y` in 10: current pixel row
- `pix_active` in 1: pixel is in the visible area
- `pix_on` out 1: cell bit for the pixel presented 2 cycles earlier
- `pix_valid` out 1: `pix_active` delayed 2 cycles
- `swap_done` out 1: one-cycle pulse when the shadow register was updated
- `drop_cnt` out 8: count of timed-out requests, saturating

## Operation
- Snapshot FSM states: IDLE, REQ.
  - IDLE: `frame_req`=0. On `vsync_start`, go to REQ and clear the wait timer to 0.
  - REQ: `frame_req`=1; the timer increments each cycle.
    - If `frame_ready`=1: shadow <= `frame_in`, `swap_done` pulses next cycle, go to IDLE.
    - Else if timer = TIMEOUT-1: keep the old shadow, increment `drop_cnt` (saturates at 255), go to IDLE.
    - `frame_ready` has priority over timeout when both occur in the same cycle.
  - `vsync_start` is ignored while in REQ; no queueing.
- Pixel pipeline:
  - Stage 1 registers:
    - inwin = (X0 <= x < X0+(COLS<<CELL_SHIFT)) && (Y0 <= y < Y0+(ROWS<<CELL_SHIFT))
    - col = (x-X0)>>CELL_SHIFT, row = (y-Y0)>>CELL_SHIFT
    - idx = row*COLS+col; implement the multiply as shifts/adds (11-bit result)
    - the delayed `pix_active` bit
  - Stage 2 registers:
    - `pix_on` = active1 && inwin1 && shadow[idx1]
    - `pix_valid` = active1
  - When inwin1=0, idx1 is don't-care and must not index out of range (force 0).
- Subtraction is done only when inwin is true; use 10-bit unsigned arithmetic with no wrap exposure.

## Timing
- Reset (`rst`=0 at a clock edge) gives:
  - FSM = IDLE, timer = 0, shadow = all 0
  - `frame_req`=0, `pix_on`=0, `pix_valid`=0, `swap_done`=0, `drop_cnt`=0
  - both pipeline stages cleared
- Reset mid-REQ aborts the request without a snapshot and does not increment `drop_cnt`.
- `frame_req` rises on the cycle after `vsync_start`. It falls on the cycle after the sample edge or timeout edge.
- Snapshot latency: if `frame_ready` is already high, the shadow updates on the edge after `frame_req` rises (2 edges after `vsync_start`).
- Pixel latency is exactly 2 cycles with throughput of 1 pixel per cycle. There are no stalls.
- A stage-2 lookup in the same cycle as a shadow update uses the pre-update shadow. New contents are visible from the next cycle.

## Test plan
- Reset, then drive `frame_in`=all 1, `frame_ready`=1, pulse `vsync_start` -> `frame_req` high 1 cycle, `swap_done` pulses, `drop_cnt`=0.
- After the snapshot with only bit 0 set: present (128,128), (135,135), (136,128), active -> `pix_on`=1,1,0 on cycles +2,+3,+4.
- Bit 1343 set: present (511,351) -> `pix_on`=1. Present (512,351), (127,200), (300,352) -> `pix_on`=0 (outside window).
- `frame_ready`=0, pulse `vsync_start` -> `frame_req` high for exactly 1024 cycles, `drop_cnt`=1, shadow unchanged, no `swap_done`.
- Run 300 timed-out requests -> `drop_cnt` saturates at 255. A second `vsync_start` during REQ does not extend or restart the wait.
- Assert `rst`=0 mid-REQ -> `frame_req`=0 next cycle, shadow = 0, `pix_on`=0 for all pixels.

Source files
------------

// File: rtl/frame_buffer_reader.sv
// Display-side frame consumer: snapshots the game bitmap at vsync into a shadow
// register and answers per-pixel cell lookups through a fixed 2-stage pipeline.
module frame_buffer_reader #(
  parameter int COLS       = 48,
  parameter int ROWS       = 28,
  parameter int CELL_SHIFT = 3,
  parameter int X0         = 128,
  parameter int Y0         = 128,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS*ROWS-1:0]   frame_in,
  input  logic                   frame_ready,
  output logic                   frame_req,
  input  logic                   vsync_start,
  input  logic [9:0]             pix_x,
  input  logic [9:0]             pix_y,
  input  logic                   pix_active,
  output logic                   pix_on,
  output logic                   pix_valid,
  output logic                   swap_done,
  output logic [7:0]             drop_cnt
);

  localparam int NCELL = COLS * ROWS;
  localparam int IDX_W = $clog2(NCELL);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CB    = $clog2(COLS + 1);
  localparam int TW    = $clog2(TIMEOUT);
  localparam int DXW   = CW + CELL_SHIFT;
  localparam int DYW   = RW + CELL_SHIFT;

  localparam logic [10:0]   X_LO       = 11'(X0);
  localparam logic [10:0]   X_HI       = 11'(X0 + (COLS << CELL_SHIFT));
  localparam logic [10:0]   Y_LO       = 11'(Y0);
  localparam logic [10:0]   Y_HI       = 11'(Y0 + (ROWS << CELL_SHIFT));
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_reg;
  logic [TW-1:0]      timer_reg;
  logic [NCELL-1:0]   shadow_reg;

  // Snapshot FSM; frame_ready wins over the timeout when both land together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      shadow_reg <= '0;
      frame_req  <= 1'b0;
      swap_done  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      swap_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (vsync_start) begin
            state_reg <= REQ;
            frame_req <= 1'b1;
            timer_reg <= '0;
          end
        end
        REQ: begin
          timer_reg <= timer_reg + TW'(1);
          if (frame_ready) begin
            shadow_reg <= frame_in;
            swap_done  <= 1'b1;
            frame_req  <= 1'b0;
            state_reg  <= IDLE;
          end else if (timer_reg == TIMER_LAST) begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            frame_req <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [10:0]      px, py;
  logic             inwin;
  logic [DXW-1:0]   dx;
  logic [DYW-1:0]   dy;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pp [CB];

  assign px    = {1'b0, pix_x};
  assign py    = {1'b0, pix_y};
  assign inwin = (px >= X_LO) && (px < X_HI) && (py >= Y_LO) && (py < Y_HI);

  // Offsets are only formed inside the window, so nothing ever wraps.
  assign dx  = inwin ? DXW'(px - X_LO) : '0;
  assign dy  = inwin ? DYW'(py - Y_LO) : '0;
  assign col = CW'(dx >> CELL_SHIFT);
  assign row = RW'(dy >> CELL_SHIFT);

  // row*COLS as a sum of shifted copies of row, one per set bit of COLS.
  generate
    for (genvar gi = 0; gi < CB; gi++) begin : g_pp
      assign pp[gi] = (((COLS >> gi) & 1) != 0) ? (IDX_W'(row) << gi) : '0;
    end
  endgenerate

  always_comb begin
    idx = IDX_W'(col);
    for (int i = 0; i < CB; i++) begin
      idx = idx + pp[i];
    end
  end

  logic             inwin1_reg;
  logic             active1_reg;
  logic [IDX_W-1:0] idx1_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      inwin1_reg  <= 1'b0;
      active1_reg <= 1'b0;
      idx1_reg    <= '0;
      pix_on      <= 1'b0;
      pix_valid   <= 1'b0;
    end else begin
      inwin1_reg  <= inwin;
      active1_reg <= pix_active;
      idx1_reg    <= inwin ? idx : '0;
      pix_on      <= active1_reg && inwin1_reg && shadow_reg[idx1_reg];
      pix_valid   <= active1_reg;
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Self-checking bench for frame_buffer_reader: directed tables and sequences plus
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_frame_buffer_reader;

  localparam int COLS  = 48;
  localparam int ROWS  = 28;
  localparam int NC    = COLS * ROWS;
  localparam int TMO   = 1024;
  localparam int S_TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NC-1:0] frame_in;
  logic          frame_ready, vsync_start, s_vsync;
  logic [9:0]    pix_x, pix_y;
  logic          pix_active;
  logic          frame_req, pix_on, pix_valid, swap_done;
  logic [7:0]    drop_cnt;
  logic          s_frame_req, s_pix_on, s_pix_valid, s_swap_done;
  logic [7:0]    s_drop_cnt;

  frame_buffer_reader dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_ready(frame_ready),
    .frame_req(frame_req), .vsync_start(vsync_start), .pix_x(pix_x), .pix_y(pix_y),
    .pix_active(pix_active), .pix_on(pix_on), .pix_valid(pix_valid),
    .swap_done(swap_done), .drop_cnt(drop_cnt)
  );

  // Short-timeout instance so drop counter saturation fits in a small run.
  frame_buffer_reader #(.TIMEOUT(S_TMO)) dut_s (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_ready(frame_ready),
    .frame_req(s_frame_req), .vsync_start(s_vsync), .pix_x(pix_x), .pix_y(pix_y),
    .pix_active(pix_active), .pix_on(s_pix_on), .pix_valid(s_pix_valid),
    .swap_done(s_swap_done), .drop_cnt(s_drop_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model state
  bit            m_req, m_swap, m1_a, m_on, m_val;
  int            m_wait, m_drop, m1_x, m1_y;
  logic [NC-1:0] m_shadow;

  function automatic bit model_pix(input int x, input int y);
    if (x < 128 || x >= 128 + COLS * 8 || y < 128 || y >= 128 + ROWS * 8) return 1'b0;
    return m_shadow[((y - 128) / 8) * COLS + (x - 128) / 8];
  endfunction

  task automatic tick();
    bit n_on, n_val, n_req, n_swap;
    int n_wait, n_drop;
    logic [NC-1:0] n_shadow;
    n_on = m1_a && model_pix(m1_x, m1_y);
    n_val = m1_a;
    n_req = m_req; n_wait = m_wait; n_drop = m_drop; n_shadow = m_shadow; n_swap = 1'b0;
    if (m_req) begin
      if (frame_ready) begin
        n_shadow = frame_in; n_swap = 1'b1; n_req = 1'b0;
      end else if (m_wait == TMO - 1) begin
        n_req = 1'b0;
        if (n_drop < 255) n_drop++;
      end else begin
        n_wait = m_wait + 1;
      end
    end else if (vsync_start) begin
      n_req = 1'b1; n_wait = 0;
    end
    @(posedge clk);
    if (!rst) begin
      m_req = 0; m_wait = 0; m_drop = 0; m_shadow = '0; m_swap = 0;
      m_on = 0; m_val = 0; m1_a = 0; m1_x = 0; m1_y = 0;
    end else begin
      m_req = n_req; m_wait = n_wait; m_drop = n_drop; m_shadow = n_shadow; m_swap = n_swap;
      m_on = n_on; m_val = n_val;
      m1_x = int'(pix_x); m1_y = int'(pix_y); m1_a = pix_active;
    end
    #1;
    chk("cyc_frame_req", int'(frame_req), int'(m_req));
    chk("cyc_swap_done", int'(swap_done), int'(m_swap));
    chk("cyc_drop_cnt", int'(drop_cnt), m_drop);
    chk("cyc_pix_on", int'(pix_on), int'(m_on));
    chk("cyc_pix_valid", int'(pix_valid), int'(m_val));
  endtask

  task automatic set_pix(input int x, input int y, input bit a);
    pix_x = 10'(x); pix_y = 10'(y); pix_active = a;
  endtask

  task automatic snapshot(input logic [NC-1:0] f);
    frame_in = f; frame_ready = 1'b1; vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    tick();
    tick();
    frame_ready = 1'b0;
  endtask

  typedef struct {
    int x;
    int y;
    bit a;
    bit exp_on;
  } pix_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_vec_t vecs[12];
    logic [NC-1:0] f;
    int cnt;
    bit seen, ok;

    vecs[0]  = '{128, 128, 1'b1, 1'b1};
    vecs[1]  = '{135, 135, 1'b1, 1'b1};
    vecs[2]  = '{136, 128, 1'b1, 1'b0};
    vecs[3]  = '{511, 351, 1'b1, 1'b1};
    vecs[4]  = '{504, 344, 1'b1, 1'b1};
    vecs[5]  = '{503, 351, 1'b1, 1'b0};
    vecs[6]  = '{512, 351, 1'b1, 1'b0};
    vecs[7]  = '{127, 200, 1'b1, 1'b0};
    vecs[8]  = '{300, 352, 1'b1, 1'b0};
    vecs[9]  = '{128, 127, 1'b1, 1'b0};
    vecs[10] = '{127, 128, 1'b1, 1'b0};
    vecs[11] = '{511, 351, 1'b0, 1'b0};

    rst = 1'b0; frame_in = '0; frame_ready = 1'b0; vsync_start = 1'b0; s_vsync = 1'b0;
    set_pix(0, 0, 1'b0);
    m_shadow = '0;
    repeat (3) tick();
    chk("rst_frame_req", int'(frame_req), 0);
    chk("rst_pix_on", int'(pix_on), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_swap_done", int'(swap_done), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b1;
    tick();

    // Snapshot with frame_ready already high: one-cycle request, then swap pulse
    frame_in = '1; frame_ready = 1'b1; vsync_start = 1'b1;
    tick();
    chk("req_rise", int'(frame_req), 1);
    vsync_start = 1'b0;
    tick();
    chk("req_fall", int'(frame_req), 0);
    chk("swap_pulse", int'(swap_done), 1);
    tick();
    chk("swap_end", int'(swap_done), 0);
    chk("drop_zero", int'(drop_cnt), 0);
    frame_ready = 1'b0;

    f = '0; f[0] = 1'b1; f[NC-1] = 1'b1;
    snapshot(f);

    // Back-to-back pixels, one per cycle
    set_pix(128, 128, 1'b1); tick();
    set_pix(135, 135, 1'b1); tick();
    chk("b2b_p0", int'(pix_on), 1);
    set_pix(136, 128, 1'b1); tick();
    chk("b2b_p1", int'(pix_on), 1);
    set_pix(0, 0, 1'b0); tick();
    chk("b2b_p2", int'(pix_on), 0);

    for (int i = 0; i < 12; i++) begin
      set_pix(vecs[i].x, vecs[i].y, vecs[i].a);
      tick();
      set_pix(0, 0, 1'b0);
      tick();
      chk($sformatf("vec%0d_on", i), int'(pix_on), int'(vecs[i].exp_on));
      chk($sformatf("vec%0d_valid", i), int'(pix_valid), int'(vecs[i].a));
    end

    // Timeout: request held for exactly TMO cycles, no swap
    frame_in = '0; frame_ready = 1'b0; vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    cnt = frame_req ? 1 : 0; seen = 1'b0;
    for (int k = 0; k < 1100 && frame_req; k++) begin
      tick();
      if (swap_done) seen = 1'b1;
      if (frame_req) cnt++;
    end
    chk("timeout_len", cnt, TMO);
    chk("timeout_drop", int'(drop_cnt), 1);
    chk("timeout_noswap", int'(seen), 0);
    set_pix(511, 351, 1'b1); tick();
    set_pix(0, 0, 1'b0); tick();
    chk("timeout_shadow_kept", int'(pix_on), 1);

    // Second vsync during REQ must not extend the wait
    vsync_start = 1'b1; tick(); vsync_start = 1'b0;
    cnt = frame_req ? 1 : 0;
    repeat (500) begin tick(); if (frame_req) cnt++; end
    vsync_start = 1'b1; tick(); vsync_start = 1'b0;
    if (frame_req) cnt++;
    for (int k = 0; k < 1100 && frame_req; k++) begin
      tick();
      if (frame_req) cnt++;
    end
    chk("revsync_len", cnt, TMO);
    chk("revsync_drop", int'(drop_cnt), 2);

    // Saturation on the short-timeout instance
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      s_vsync = 1'b1; tick(); s_vsync = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (s_swap_done) seen = 1'b1;
        if (!s_frame_req) begin ok = 1'b1; break; end
      end
      if (!ok) chk("sat_wait_bound", 0, 1);
      if (i == 0)   chk("sat_first", int'(s_drop_cnt), 1);
      if (i == 253) chk("sat_254", int'(s_drop_cnt), 254);
      if (i == 254) chk("sat_255", int'(s_drop_cnt), 255);
    end
    tick();
    chk("sat_hold", int'(s_drop_cnt), 255);
    chk("sat_noswap", int'(seen), 0);

    // Reset in the middle of a request
    snapshot('1);
    vsync_start = 1'b1; tick(); vsync_start = 1'b0;
    repeat (10) tick();
    rst = 1'b0; tick();
    chk("midreq_req", int'(frame_req), 0);
    chk("midreq_drop", int'(drop_cnt), 0);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      set_pix($urandom_range(128, 511), $urandom_range(128, 351), 1'b1);
      tick();
      if (pix_on) seen = 1'b1;
    end
    set_pix(0, 0, 1'b0);
    repeat (2) begin tick(); if (pix_on) seen = 1'b1; end
    chk("midreq_shadow_clear", int'(seen), 0);
    repeat (1100) tick();
    chk("midreq_no_late_drop", int'(drop_cnt), 0);
    chk("midreq_idle", int'(frame_req), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 16 == 0) begin
        for (int w = 0; w < NC / 32; w++) frame_in[w*32 +: 32] = $urandom();
      end
      frame_ready = ($urandom_range(0, 2) == 0);
      vsync_start = ($urandom_range(0, 39) == 0);
      set_pix($urandom_range(100, 540), $urandom_range(100, 380), $urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
